// File: rtl/menu_list_renderer.sv
// Menu list renderer: draws N_ITEMS item boxes, moves a cursor on button pulses and
// offers the chosen item through sel_valid/sel_ready. Define MENU_BLINK_EN for the blinking fill.
module menu_list_renderer #(
    parameter int N_ITEMS      = 4,
    parameter int ITEM_X0      = 160,
    parameter int ITEM_W       = 320,
    parameter int ITEM_Y0      = 120,
    parameter int ITEM_H       = 40,
    parameter int ITEM_GAP     = 20,
    parameter int BORDER       = 4,
    parameter int WRAP         = 1,
    parameter int BLINK_FRAMES = 30,
    localparam int IW          = (N_ITEMS > 2) ? $clog2(N_ITEMS) : 1
) (
    input  logic          clk_in,
    input  logic          i_rst,
    input  logic          menu_en,
    input  logic          o_active,
    input  logic [9:0]    o_x,
    input  logic [8:0]    o_y,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_ok,
    input  logic          sel_ready,
    output logic          sel_valid,
    output logic [IW-1:0] sel_idx,
    output logic          pix_on,
    output logic          pix_hl
);

    // state     | meaning
    // S_IDLE    | menu hidden, buttons ignored
    // S_BROWSE  | cursor follows up/down, ok offers the selection
    // S_CONFIRM | selection offered, waiting for sel_ready
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BROWSE  = 2'd1,
        S_CONFIRM = 2'd2
    } state_t;

    localparam int            PITCH = ITEM_H + ITEM_GAP;
    localparam logic [IW-1:0] LAST  = IW'(N_ITEMS - 1);
    localparam logic [9:0]    X_LO  = 10'(ITEM_X0);
    localparam logic [9:0]    X_HI  = 10'(ITEM_X0 + ITEM_W - 1);
    localparam logic [9:0]    XI_LO = 10'(ITEM_X0 + BORDER);
    localparam logic [9:0]    XI_HI = 10'(ITEM_X0 + ITEM_W - 1 - BORDER);

    state_t          state_q, state_d;
    logic [IW-1:0]   cursor_q, cursor_d;
    logic [IW-1:0]   sel_idx_q, sel_idx_d;
    logic [IW-1:0]   disp_q, disp_d;
    logic            prev_zero_q;
    logic            frame_start;
    logic            showing;
    logic            browsing;
    logic            blink_on;

    logic [9:0]      px_x_q, px_y_q;
    logic            px_act_q;
    logic [N_ITEMS-1:0] in_box, in_edge;
    logic            hl_d, on_d, gate_d;
    logic            pix_on_q, pix_hl_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!menu_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_BROWSE;
                S_BROWSE:  if (btn_ok) state_d = S_CONFIRM;
                S_CONFIRM: if (sel_ready) state_d = S_BROWSE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_valid = (state_q == S_CONFIRM);
        showing   = (state_q != S_IDLE);
        browsing  = (state_q == S_BROWSE) && menu_en;
    end

    // ---------------- cursor and selection ----------------
    always_comb begin
        cursor_d  = cursor_q;
        sel_idx_d = sel_idx_q;
        if (browsing && btn_ok) begin
            sel_idx_d = cursor_q;
        end else if (browsing && (btn_up ^ btn_down)) begin
            if (btn_up) begin
                if (cursor_q == '0) cursor_d = (WRAP != 0) ? LAST : '0;
                else                cursor_d = cursor_q - 1'b1;
            end else begin
                if (cursor_q == LAST) cursor_d = (WRAP != 0) ? '0 : LAST;
                else                  cursor_d = cursor_q + 1'b1;
            end
        end
    end

    assign frame_start = (o_x == 10'd0) && (o_y == 9'd0) && !prev_zero_q;
    assign disp_d      = frame_start ? cursor_q : disp_q;

    always_ff @(posedge clk_in or posedge i_rst) begin
        if (i_rst) begin
            cursor_q    <= '0;
            sel_idx_q   <= '0;
            disp_q      <= '0;
            prev_zero_q <= 1'b0;
        end else begin
            cursor_q    <= cursor_d;
            sel_idx_q   <= sel_idx_d;
            disp_q      <= disp_d;
            prev_zero_q <= (o_x == 10'd0) && (o_y == 9'd0);
        end
    end

    assign sel_idx = sel_idx_q;

    // ---------------- blink ----------------
`ifdef MENU_BLINK_EN
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;

    // A newly displayed item always starts with a full on half-period.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (frame_start) begin
            if (cursor_q != disp_q) begin
                blink_cnt_d = '0;
                blink_ph_d  = 1'b1;
            end else if (blink_cnt_q == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge i_rst) begin
        if (i_rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
        end
    end

    assign blink_on = blink_ph_q;
`else
    assign blink_on = 1'b1;
`endif

    // ---------------- pixel pipeline ----------------
    always_ff @(posedge clk_in or posedge i_rst) begin
        if (i_rst) begin
            px_x_q   <= '0;
            px_y_q   <= '0;
            px_act_q <= 1'b0;
        end else begin
            px_x_q   <= o_x;
            px_y_q   <= {1'b0, o_y};
            px_act_q <= o_active;
        end
    end

    always_comb begin
        in_box  = '0;
        in_edge = '0;
        hl_d    = 1'b0;
        for (int k = 0; k < N_ITEMS; k++) begin
            in_box[k] = (px_x_q >= X_LO) && (px_x_q <= X_HI) &&
                        (px_y_q >= 10'(ITEM_Y0 + k * PITCH)) &&
                        (px_y_q <= 10'(ITEM_Y0 + k * PITCH + ITEM_H - 1));
            in_edge[k] = in_box[k] &&
                         ((px_x_q < XI_LO) || (px_x_q > XI_HI) ||
                          (px_y_q < 10'(ITEM_Y0 + k * PITCH + BORDER)) ||
                          (px_y_q > 10'(ITEM_Y0 + k * PITCH + ITEM_H - 1 - BORDER)));
            if (IW'(k) == disp_q) hl_d = in_box[k];
        end
        on_d   = (|in_edge) || (hl_d && blink_on);
        gate_d = px_act_q && menu_en && showing;
    end

    always_ff @(posedge clk_in or posedge i_rst) begin
        if (i_rst) begin
            pix_on_q <= 1'b0;
            pix_hl_q <= 1'b0;
        end else begin
            pix_on_q <= gate_d && on_d;
            pix_hl_q <= gate_d && hl_d;
        end
    end

    assign pix_on = pix_on_q;
    assign pix_hl = pix_hl_q;

endmodule

// File: tb/tb_menu_list_renderer.sv
// Directed bench for menu_list_renderer with default parameters; blink expectations
// follow MENU_BLINK_EN.
module tb_menu_list_renderer;

`ifdef MENU_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       i_rst;
    logic       menu_en;
    logic       o_active;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       btn_up, btn_down, btn_ok, sel_ready;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic       pix_on, pix_hl;

    int vectors    = 0;
    int miscompares = 0;

    menu_list_renderer dut (
        .clk_in   (clk_in),
        .i_rst    (i_rst),
        .menu_en  (menu_en),
        .o_active (o_active),
        .o_x      (o_x),
        .o_y      (o_y),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_ok   (btn_ok),
        .sel_ready(sel_ready),
        .sel_valid(sel_valid),
        .sel_idx  (sel_idx),
        .pix_on   (pix_on),
        .pix_hl   (pix_hl)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input string tag, input int x, input int y, input bit act,
                       input bit exp_on, input bit exp_hl);
        o_x = 10'(x);
        o_y = 9'(y);
        o_active = act;
        tick();
        tick();
        chk({tag, ".on"}, {31'd0, pix_on}, {31'd0, exp_on});
        chk({tag, ".hl"}, {31'd0, pix_hl}, {31'd0, exp_hl});
    endtask

    task automatic press(input bit up, input bit down, input bit ok);
        btn_up = up;
        btn_down = down;
        btn_ok = ok;
        tick();
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_ok = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            o_x = 10'd0;
            o_y = 9'd0;
            tick();
            o_x = 10'd1;
            tick();
        end
    endtask

    // Offers the cursor via ok, checks it, then completes the handshake.
    task automatic ok_check(input string tag, input int exp_idx);
        press(1'b0, 1'b0, 1'b1);
        chk({tag, ".valid"}, {31'd0, sel_valid}, 32'd1);
        chk({tag, ".idx"}, {30'd0, sel_idx}, 32'(exp_idx));
        sel_ready = 1'b1;
        tick();
        sel_ready = 1'b0;
        chk({tag, ".drop"}, {31'd0, sel_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        menu_en = 1'b0;
        o_active = 1'b0;
        o_x = 10'd5;
        o_y = 9'd5;
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_ok = 1'b0;
        sel_ready = 1'b0;
        tick();
        tick();
        chk("rst.pix_on", {31'd0, pix_on}, 32'd0);
        chk("rst.pix_hl", {31'd0, pix_hl}, 32'd0);
        chk("rst.sel_valid", {31'd0, sel_valid}, 32'd0);
        chk("rst.sel_idx", {30'd0, sel_idx}, 32'd0);

        i_rst = 1'b0;
        menu_en = 1'b1;
        pix("first_item", 170, 140, 1'b1, 1'b1, 1'b1);
        pix("item1_idle", 170, 200, 1'b1, 1'b0, 1'b0);

        // tear-free cursor move
        o_x = 10'd170;
        o_y = 9'd200;
        press(1'b0, 1'b1, 1'b0);
        tick();
        chk("tear.hl_a", {31'd0, pix_hl}, 32'd0);
        tick();
        chk("tear.hl_b", {31'd0, pix_hl}, 32'd0);
        chk("tear.on_b", {31'd0, pix_on}, 32'd0);
        frames(1);
        pix("tear.new", 170, 200, 1'b1, 1'b1, 1'b1);
        pix("tear.old_fill", 170, 140, 1'b1, 1'b0, 1'b0);
        pix("tear.old_edge", 161, 140, 1'b1, 1'b1, 1'b0);
        pix("tear.bottom_edge", 300, 219, 1'b1, 1'b1, 1'b1);
        pix("tear.outside", 480, 200, 1'b1, 1'b0, 1'b0);

        // cursor wrap rules (cursor is 1 here)
        press(1'b1, 1'b0, 1'b0);
        ok_check("wrap.at0", 0);
        press(1'b1, 1'b0, 1'b0);
        ok_check("wrap.up0", 3);
        press(1'b0, 1'b1, 1'b0);
        ok_check("wrap.down3", 0);
        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 1'b0);
        ok_check("wrap.four_down", 0);
        press(1'b1, 1'b1, 1'b0);
        ok_check("wrap.both", 0);
        press(1'b0, 1'b1, 1'b1);
        chk("okwins.valid", {31'd0, sel_valid}, 32'd1);
        chk("okwins.idx", {30'd0, sel_idx}, 32'd0);
        sel_ready = 1'b1;
        tick();
        sel_ready = 1'b0;
        ok_check("okwins.cursor", 0);

        // handshake hold
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk("hs.valid", {31'd0, sel_valid}, 32'd1);
        chk("hs.idx", {30'd0, sel_idx}, 32'd2);
        for (int i = 0; i < 10; i++) begin
            btn_down = (i % 2 == 0);
            tick();
            chk("hs.hold_valid", {31'd0, sel_valid}, 32'd1);
            chk("hs.hold_idx", {30'd0, sel_idx}, 32'd2);
        end
        btn_down = 1'b0;
        sel_ready = 1'b1;
        tick();
        sel_ready = 1'b0;
        chk("hs.drop", {31'd0, sel_valid}, 32'd0);
        press(1'b0, 1'b1, 1'b0);
        ok_check("hs.after", 3);

        // blink (cursor 3, display still 1)
        frames(1);
        pix("blink.start", 170, 310, 1'b1, 1'b1, 1'b1);
        frames(30);
        pix("blink.off", 170, 310, 1'b1, !BLINK, 1'b1);
        pix("blink.off_edge", 161, 310, 1'b1, 1'b1, 1'b1);
        frames(30);
        pix("blink.on_again", 170, 310, 1'b1, 1'b1, 1'b1);
        frames(30);
        press(1'b0, 1'b1, 1'b0);
        pix("blink.move_pending", 170, 310, 1'b1, !BLINK, 1'b1);
        frames(1);
        pix("blink.new_fill", 170, 140, 1'b1, 1'b1, 1'b1);
        pix("blink.prev_fill", 170, 310, 1'b1, 1'b0, 1'b0);
        frames(29);
        pix("blink.restart29", 170, 140, 1'b1, 1'b1, 1'b1);
        frames(1);
        pix("blink.restart30", 170, 140, 1'b1, !BLINK, 1'b1);

        // abort and blanking (cursor 0)
        press(1'b0, 1'b0, 1'b1);
        chk("abort.valid_on", {31'd0, sel_valid}, 32'd1);
        o_x = 10'd161;
        o_y = 9'd140;
        o_active = 1'b1;
        menu_en = 1'b0;
        tick();
        chk("abort.valid_off", {31'd0, sel_valid}, 32'd0);
        tick();
        chk("abort.pix_on", {31'd0, pix_on}, 32'd0);
        menu_en = 1'b1;
        pix("abort.reshow", 161, 140, 1'b1, 1'b1, 1'b1);
        ok_check("abort.cursor", 0);
        pix("blank.inactive", 170, 140, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
